// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, ALU operation encoding, immediate and
// result selectors, and the decoded control bundle.
package rv32i_pkg;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcIAlu   = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcFence  = 7'b0001111;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  typedef enum logic [3:0] {
    AluAdd   = 4'b0000,
    AluSub   = 4'b0001,
    AluAnd   = 4'b0010,
    AluOr    = 4'b0011,
    AluXor   = 4'b0100,
    AluSlt   = 4'b0101,
    AluSltu  = 4'b0110,
    AluSll   = 4'b0111,
    AluSrl   = 4'b1000,
    AluSra   = 4'b1001,
    AluPassb = 4'b1010
  } alu_op_t;

  typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ} imm_src_t;

  typedef enum logic [1:0] {
    ResAlu = 2'b00,
    ResMem = 2'b01,
    ResPc4 = 2'b10
  } result_src_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic        alu_src_a;
    logic        illegal;
    result_src_t result_src;
    alu_op_t     alu_control;
    imm_src_t    imm_src;
  } ctrl_t;

endpackage

// File: rtl/regfile.sv
// 32-entry register file: x0 hardwired to zero, synchronous write, combinational read.
// REGFILE_BYPASS_EN: same-cycle write is forwarded to the read ports (write-first).
module regfile #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] raddr1_i,
  input  logic [AddrWidth-1:0] raddr2_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata1_o,
  output logic [DataWidth-1:0] rdata2_o
);

  localparam int unsigned NumRegs = 2 ** AddrWidth;

  logic [DataWidth-1:0] mem_q [NumRegs];

  // Storage: cleared by reset, writes to x0 dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports: x0 forced to zero, optional write-first forwarding
  always_comb begin
    rdata1_o = mem_q[raddr1_i];
    rdata2_o = mem_q[raddr2_i];
`ifdef REGFILE_BYPASS_EN
    if (we_i && (waddr_i != '0) && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
    if (we_i && (waddr_i != '0) && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
`endif
    if (raddr1_i == '0) rdata1_o = '0;
    if (raddr2_i == '0) rdata2_o = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: main/ALU decoders, immediate extender, register file and
// the decode/execute pipeline register with flush-to-bubble.
// Optional macro REGFILE_BYPASS_EN enables write-first register file reads.
module decode_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] InstrD,
  input  logic [DATA_WIDTH-1:0] PCd,
  input  logic [DATA_WIDTH-1:0] PCPlus4D,
  input  logic                  FlushE,
  input  logic                  RegWriteW,
  input  logic [ADDR_WIDTH-1:0] RdW,
  input  logic [DATA_WIDTH-1:0] ResultW,
  output logic [ADDR_WIDTH-1:0] Rs1D,
  output logic [ADDR_WIDTH-1:0] Rs2D,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic                  ALUSrcE,
  output logic                  ALUSrcAE,
  output logic                  IllegalE,
  output logic [1:0]            ResultSrcE,
  output logic [3:0]            ALUControlE,
  output logic [2:0]            Funct3E,
  output logic [DATA_WIDTH-1:0] RD1E,
  output logic [DATA_WIDTH-1:0] RD2E,
  output logic [DATA_WIDTH-1:0] ImmExtE,
  output logic [DATA_WIDTH-1:0] PCE,
  output logic [DATA_WIDTH-1:0] PCPlus4E,
  output logic [ADDR_WIDTH-1:0] Rs1E,
  output logic [ADDR_WIDTH-1:0] Rs2E,
  output logic [ADDR_WIDTH-1:0] RdE
);

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic                  alu_src;
    logic                  alu_src_a;
    logic                  illegal;
    result_src_t           result_src;
    alu_op_t               alu_control;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [ADDR_WIDTH-1:0] rd;
  } de_t;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic                  funct7b5;
  logic                  alu_by_funct;
  ctrl_t                 ctrl;
  logic [31:0]           imm32;
  logic [DATA_WIDTH-1:0] rd1, rd2;
  de_t                   de_d, de_q;

  assign opcode   = InstrD[6:0];
  assign funct3   = InstrD[14:12];
  assign funct7b5 = InstrD[30];
  assign Rs1D     = InstrD[19:15];
  assign Rs2D     = InstrD[24:20];

  regfile #(
    .DataWidth(DATA_WIDTH),
    .AddrWidth(ADDR_WIDTH)
  ) u_regfile (
    .clk_i   (clk),
    .rst_ni  (rst),
    .raddr1_i(Rs1D),
    .raddr2_i(Rs2D),
    .we_i    (RegWriteW),
    .waddr_i (RdW),
    .wdata_i (ResultW),
    .rdata1_o(rd1),
    .rdata2_o(rd2)
  );

  // Main decoder plus funct3/funct7 ALU decoder for R-type and I-ALU
  always_comb begin
    ctrl         = '0;
    ctrl.alu_control = AluAdd;
    ctrl.imm_src     = ImmI;
    ctrl.result_src  = ResAlu;
    alu_by_funct = 1'b0;
    unique case (opcode)
      OpcR: begin
        ctrl.reg_write = 1'b1;
        alu_by_funct   = 1'b1;
      end
      OpcIAlu: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        alu_by_funct   = 1'b1;
      end
      OpcLoad: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = ResMem;
      end
      OpcStore: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = ImmS;
      end
      OpcBranch: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = AluSub;
        ctrl.imm_src     = ImmB;
      end
      OpcJal: begin
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = ResPc4;
        ctrl.imm_src    = ImmJ;
      end
      OpcJalr: begin
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = ResPc4;
      end
      OpcLui: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = AluPassb;
        ctrl.imm_src     = ImmU;
      end
      OpcAuipc: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.imm_src   = ImmU;
      end
      // FENCE, SYSTEM and unknown opcodes decode as illegal
      default: ctrl.illegal = 1'b1;
    endcase

    if (alu_by_funct) begin
      unique case (funct3)
        3'b000:  ctrl.alu_control = (opcode == OpcR && funct7b5) ? AluSub : AluAdd;
        3'b001:  ctrl.alu_control = AluSll;
        3'b010:  ctrl.alu_control = AluSlt;
        3'b011:  ctrl.alu_control = AluSltu;
        3'b100:  ctrl.alu_control = AluXor;
        3'b101:  ctrl.alu_control = funct7b5 ? AluSra : AluSrl;
        3'b110:  ctrl.alu_control = AluOr;
        default: ctrl.alu_control = AluAnd;
      endcase
    end
  end

  // Immediate extender, sign taken from InstrD[31] in every format
  always_comb begin
    unique case (ctrl.imm_src)
      ImmS:    imm32 = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      ImmB:    imm32 = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                        InstrD[11:8], 1'b0};
      ImmU:    imm32 = {InstrD[31:12], 12'b0};
      ImmJ:    imm32 = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20],
                        InstrD[30:21], 1'b0};
      default: imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
    endcase
  end

  // Assemble the next D/E register contents
  always_comb begin
    de_d             = '0;
    de_d.reg_write   = ctrl.reg_write;
    de_d.mem_write   = ctrl.mem_write;
    de_d.jump        = ctrl.jump;
    de_d.branch      = ctrl.branch;
    de_d.alu_src     = ctrl.alu_src;
    de_d.alu_src_a   = ctrl.alu_src_a;
    de_d.illegal     = ctrl.illegal;
    de_d.result_src  = ctrl.result_src;
    de_d.alu_control = ctrl.alu_control;
    de_d.funct3      = funct3;
    de_d.rd1         = rd1;
    de_d.rd2         = rd2;
    de_d.imm_ext     = DATA_WIDTH'($signed(imm32));
    de_d.pc          = PCd;
    de_d.pc_plus4    = PCPlus4D;
    de_d.rs1         = Rs1D;
    de_d.rs2         = Rs2D;
    de_d.rd          = InstrD[11:7];
  end

  // D/E pipeline register; flush loads an all-zero bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      de_q <= '0;
    end else if (FlushE) begin
      de_q <= '0;
    end else begin
      de_q <= de_d;
    end
  end

  assign RegWriteE   = de_q.reg_write;
  assign MemWriteE   = de_q.mem_write;
  assign JumpE       = de_q.jump;
  assign BranchE     = de_q.branch;
  assign ALUSrcE     = de_q.alu_src;
  assign ALUSrcAE    = de_q.alu_src_a;
  assign IllegalE    = de_q.illegal;
  assign ResultSrcE  = de_q.result_src;
  assign ALUControlE = de_q.alu_control;
  assign Funct3E     = de_q.funct3;
  assign RD1E        = de_q.rd1;
  assign RD2E        = de_q.rd2;
  assign ImmExtE     = de_q.imm_ext;
  assign PCE         = de_q.pc;
  assign PCPlus4E    = de_q.pc_plus4;
  assign Rs1E        = de_q.rs1;
  assign Rs2E        = de_q.rs2;
  assign RdE         = de_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes expected D/E contents,
// a monitor pops and compares one entry after each clock edge.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCd, PCPlus4D, ResultW;
  logic        FlushE, RegWriteW;
  logic [4:0]  RdW, Rs1D, Rs2D;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;

  decode_stage dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCd(PCd), .PCPlus4D(PCPlus4D),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE),
    .IllegalE(IllegalE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic        rw, mw, j, b, as, asa, ill;
    logic [1:0]  rs;
    logic [3:0]  alu;
    logic        chk_alu;
    logic [2:0]  f3;
    logic [31:0] rd1, rd2, imm;
    logic        chk_imm;
    logic [31:0] pc, pc4;
    logic [4:0]  r1, r2, rd;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int tag, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL v%0d %s: got %h want %h", tag, name, act, req);
    end
  endtask

  // Default expectation: register fields straight from the encoding, no controls
  function automatic exp_t base(input int tag, input logic [31:0] ins, input logic [31:0] pc);
    exp_t x;
    x.tag = tag; x.rw = 0; x.mw = 0; x.j = 0; x.b = 0; x.as = 0; x.asa = 0; x.ill = 0;
    x.rs = 2'b00; x.alu = 4'h0; x.chk_alu = 1; x.f3 = ins[14:12];
    x.rd1 = 0; x.rd2 = 0; x.imm = 0; x.chk_imm = 1; x.pc = pc; x.pc4 = pc + 32'd4;
    x.r1 = ins[19:15]; x.r2 = ins[24:20]; x.rd = ins[11:7];
    return x;
  endfunction

  function automatic exp_t bubble(input int tag);
    exp_t x;
    x = base(tag, 32'h0, 32'h0);
    x.pc4 = 32'h0;
    return x;
  endfunction

  task automatic drive(input int tag, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic we, input logic [4:0] rd,
                       input logic [31:0] res);
    @(posedge clk);
    #2;
    InstrD = ins; PCd = pc; PCPlus4D = pc + 32'd4; FlushE = fl;
    RegWriteW = we; RdW = rd; ResultW = res;
    #1;
    chk("Rs1D", tag, 32'(Rs1D), 32'(ins[19:15]));
    chk("Rs2D", tag, 32'(Rs2D), 32'(ins[24:20]));
  endtask

  // Drive one vector and leave its default expectation in e for the caller to edit
  task automatic issue(input int tag, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic we, input logic [4:0] rd,
                       input logic [31:0] res);
    drive(tag, ins, pc, fl, we, rd, res);
    e = fl ? bubble(tag) : base(tag, ins, pc);
  endtask

  task automatic chk_all_zero(input int tag);
    chk("rst RegWriteE", tag, 32'(RegWriteE), 0);
    chk("rst MemWriteE", tag, 32'(MemWriteE), 0);
    chk("rst JumpE", tag, 32'(JumpE), 0);
    chk("rst BranchE", tag, 32'(BranchE), 0);
    chk("rst ALUSrcE", tag, 32'(ALUSrcE), 0);
    chk("rst ALUSrcAE", tag, 32'(ALUSrcAE), 0);
    chk("rst IllegalE", tag, 32'(IllegalE), 0);
    chk("rst ResultSrcE", tag, 32'(ResultSrcE), 0);
    chk("rst ALUControlE", tag, 32'(ALUControlE), 0);
    chk("rst Funct3E", tag, 32'(Funct3E), 0);
    chk("rst RD1E", tag, RD1E, 0);
    chk("rst RD2E", tag, RD2E, 0);
    chk("rst ImmExtE", tag, ImmExtE, 0);
    chk("rst PCE", tag, PCE, 0);
    chk("rst PCPlus4E", tag, PCPlus4E, 0);
    chk("rst Rs1E", tag, 32'(Rs1E), 0);
    chk("rst Rs2E", tag, 32'(Rs2E), 0);
    chk("rst RdE", tag, 32'(RdE), 0);
  endtask

  // Monitor: one expectation retires per clock edge
  always @(posedge clk) begin : mon
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("RegWriteE", x.tag, 32'(RegWriteE), 32'(x.rw));
      chk("MemWriteE", x.tag, 32'(MemWriteE), 32'(x.mw));
      chk("JumpE", x.tag, 32'(JumpE), 32'(x.j));
      chk("BranchE", x.tag, 32'(BranchE), 32'(x.b));
      chk("ALUSrcE", x.tag, 32'(ALUSrcE), 32'(x.as));
      chk("ALUSrcAE", x.tag, 32'(ALUSrcAE), 32'(x.asa));
      chk("IllegalE", x.tag, 32'(IllegalE), 32'(x.ill));
      chk("ResultSrcE", x.tag, 32'(ResultSrcE), 32'(x.rs));
      if (x.chk_alu) chk("ALUControlE", x.tag, 32'(ALUControlE), 32'(x.alu));
      chk("Funct3E", x.tag, 32'(Funct3E), 32'(x.f3));
      chk("RD1E", x.tag, RD1E, x.rd1);
      chk("RD2E", x.tag, RD2E, x.rd2);
      if (x.chk_imm) chk("ImmExtE", x.tag, ImmExtE, x.imm);
      chk("PCE", x.tag, PCE, x.pc);
      chk("PCPlus4E", x.tag, PCPlus4E, x.pc4);
      chk("Rs1E", x.tag, 32'(Rs1E), 32'(x.r1));
      chk("Rs2E", x.tag, 32'(Rs2E), 32'(x.r2));
      chk("RdE", x.tag, 32'(RdE), 32'(x.rd));
    end
  end

  initial begin
    InstrD = 0; PCd = 0; PCPlus4D = 0; FlushE = 0; RegWriteW = 0; RdW = 0; ResultW = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2 chk_all_zero(0);
    @(posedge clk);
    #2 rst = 1'b1;

    // addi x5,x0,7
    issue(1, 32'h00700293, 32'h100, 0, 0, 0, 0);
    e.rw = 1; e.as = 1; e.imm = 32'd7; q.push_back(e);
    // beq x0,x0,-4
    issue(2, 32'hFE000EE3, 32'h104, 0, 0, 0, 0);
    e.b = 1; e.alu = 4'h1; e.imm = 32'hFFFFFFFC; q.push_back(e);
    // add x6,x5,x0 while x5 <= DEADBEEF is written back
    issue(3, 32'h00028333, 32'h108, 0, 1, 5'd5, 32'hDEADBEEF);
    e.rw = 1; e.chk_imm = 0;
`ifdef REGFILE_BYPASS_EN
    e.rd1 = 32'hDEADBEEF;
`else
    e.rd1 = 32'h0;
`endif
    q.push_back(e);
    // same add again: stored value now visible
    issue(4, 32'h00028333, 32'h10C, 0, 0, 0, 0);
    e.rw = 1; e.chk_imm = 0; e.rd1 = 32'hDEADBEEF; q.push_back(e);
    // add x7,x0,x5 with a writeback to x0 (never forwarded or stored)
    issue(5, 32'h005003B3, 32'h110, 0, 1, 5'd0, 32'h1234);
    e.rw = 1; e.chk_imm = 0; e.rd2 = 32'hDEADBEEF; q.push_back(e);
    // add x7,x0,x0
    issue(6, 32'h000003B3, 32'h114, 0, 0, 0, 0);
    e.rw = 1; e.chk_imm = 0; q.push_back(e);
    // sub x8,x5,x5
    issue(7, 32'h40528433, 32'h118, 0, 0, 0, 0);
    e.rw = 1; e.chk_imm = 0; e.alu = 4'h1; e.rd1 = 32'hDEADBEEF; e.rd2 = 32'hDEADBEEF;
    q.push_back(e);
    // srai x9,x5,3
    issue(8, 32'h4032D493, 32'h11C, 0, 0, 0, 0);
    e.rw = 1; e.as = 1; e.alu = 4'h9; e.imm = 32'h403; e.rd1 = 32'hDEADBEEF; q.push_back(e);
    // flushed lw x1,0(x2) while x3 <= CAFEF00D lands
    issue(9, 32'h00012083, 32'h120, 1, 1, 5'd3, 32'hCAFEF00D);
    q.push_back(e);
    // add x10,x3,x0
    issue(10, 32'h00018533, 32'h124, 0, 0, 0, 0);
    e.rw = 1; e.chk_imm = 0; e.rd1 = 32'hCAFEF00D; q.push_back(e);
    // lw x1,0(x2)
    issue(11, 32'h00012083, 32'h128, 0, 0, 0, 0);
    e.rw = 1; e.as = 1; e.rs = 2'b01; q.push_back(e);
    // sw x5,8(x3)
    issue(12, 32'h0051A423, 32'h12C, 0, 0, 0, 0);
    e.mw = 1; e.as = 1; e.imm = 32'd8; e.rd1 = 32'hCAFEF00D; e.rd2 = 32'hDEADBEEF;
    q.push_back(e);
    // jal x1,+16
    issue(13, 32'h010000EF, 32'h130, 0, 0, 0, 0);
    e.j = 1; e.rw = 1; e.rs = 2'b10; e.chk_alu = 0; e.imm = 32'd16; q.push_back(e);
    // jalr x1,4(x5)
    issue(14, 32'h004280E7, 32'h134, 0, 0, 0, 0);
    e.j = 1; e.rw = 1; e.as = 1; e.rs = 2'b10; e.imm = 32'd4; e.rd1 = 32'hDEADBEEF;
    q.push_back(e);
    // lui x11,0x12345
    issue(15, 32'h123455B7, 32'h138, 0, 0, 0, 0);
    e.rw = 1; e.as = 1; e.alu = 4'hA; e.imm = 32'h12345000; e.rd2 = 32'hCAFEF00D;
    q.push_back(e);
    // auipc x12,0x1
    issue(16, 32'h00001617, 32'h13C, 0, 0, 0, 0);
    e.rw = 1; e.as = 1; e.asa = 1; e.imm = 32'h1000; q.push_back(e);
    // unsupported opcode, FENCE, ECALL
    issue(17, 32'h0000007F, 32'h140, 0, 0, 0, 0);
    e.ill = 1; e.chk_alu = 0; e.chk_imm = 0; q.push_back(e);
    issue(18, 32'h0000000F, 32'h144, 0, 0, 0, 0);
    e.ill = 1; e.chk_alu = 0; e.chk_imm = 0; q.push_back(e);
    issue(19, 32'h00000073, 32'h148, 0, 0, 0, 0);
    e.ill = 1; e.chk_alu = 0; e.chk_imm = 0; q.push_back(e);

    // Mid-run reset with a writeback to x13 pending at the next edge
    drive(20, 32'h00700293, 32'h14C, 0, 1, 5'd13, 32'h5555);
    chk("pre-reset IllegalE", 20, 32'(IllegalE), 1);
    #2 rst = 1'b0;
    #1 chk_all_zero(21);
    @(posedge clk);
    #2 RegWriteW = 0;
    rst = 1'b1;

    // add x0,xi,xi: every register must read back zero
    for (int i = 1; i < 32; i++) begin
      logic [31:0] ins;
      ins = (32'(i) << 20) | (32'(i) << 15) | 32'h33;
      issue(100 + i, ins, 32'h200 + 32'(4 * i), 0, 0, 0, 0);
      e.rw = 1; e.chk_imm = 0; q.push_back(e);
    end

    repeat (4) @(posedge clk);
    #2 chk("queue drained", 0, 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the 5-stage RV32I pipeline, directly downstream of the fetch stage and its fetch/decode pipeline register. It consumes InstrD/PCd/PCPlus4D and decodes control signals. It holds the 32×32 register file (written by writeback), sign-extends immediates, and registers everything into the decode/execute pipeline register. The pipeline register supports hazard-unit flush (bubble insertion).

## Interface
- DATA_WIDTH, 32, datapath width
- ADDR_WIDTH, 5, register index width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted at 0)
- InstrD  input  DATA_WIDTH  instruction from fetch register
- PCd  input  DATA_WIDTH  PC of InstrD
- PCPlus4D  input  DATA_WIDTH  PCd+4
- FlushE  input  1  load bubble into D/E register this edge
- RegWriteW  input  1  writeback enable
- RdW  input  ADDR_WIDTH  writeback destination
- ResultW  input  DATA_WIDTH  writeback data
- Rs1D, Rs2D  output  ADDR_WIDTH  combinational source indices to hazard unit
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcAE, IllegalE  output  1 each  registered controls
- ResultSrcE  output  2  00 ALU, 01 memory, 10 PC+4
- ALUControlE  output  4  ALU op (package encoding)
- Funct3E  output  3  branch/load/store qualifier
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  output  DATA_WIDTH  registered data
- Rs1E, Rs2E, RdE  output  ADDR_WIDTH  registered indices

## Operation
- Main decoder by opcode:
  - R-type: RegWrite, ALU result.
  - I-ALU: RegWrite, ALUSrc.
  - Load: RegWrite, ALUSrc, ResultSrc=01, ADD.
  - Store: MemWrite, ALUSrc, ADD.
  - Branch: Branch, SUB.
  - JAL: Jump, RegWrite, ResultSrc=10.
  - JALR: Jump, RegWrite, ALUSrc, ResultSrc=10, ADD.
  - LUI: RegWrite, ALUSrc, PASSB.
  - AUIPC: RegWrite, ALUSrc, ALUSrcA=1 (PC), ADD.
- ALU decoder from funct3/funct7[5]:
  - SUB only for R-type with funct7[5]=1.
  - SRA/SRL selected by funct7[5].
- Immediate extension (I/S/B/U/J), always sign-extended from InstrD[31]. B and J immediates have bit0=0.
- Illegal handling:
  - Unsupported opcode: IllegalE=1; RegWrite/MemWrite/Jump/Branch forced 0.
  - FENCE/SYSTEM are treated as illegal.
- Register file:
  - 32 entries; x0 reads 0 and writes to x0 are ignored.
  - Write on rising clk when RegWriteW=1.
  - Reads are combinational on InstrD[19:15]/[24:20].
- D/E register:
  - Every edge: captures decoded values.
  - FlushE=1: captures a bubble (all controls 0, IllegalE 0, all data/index fields 0).
- Flush does not block the same-cycle register-file write.

## Timing
- Reset (rst=0, asynchronous): all E outputs 0; all 32 registers 0; held until rst=1, then the first capture is at the next rising edge.
- Reset mid-operation clears registers and E outputs immediately; in-flight writeback is lost.
- Latency: InstrD sampled at edge N appears on E outputs after edge N (1 cycle).
- Rs1D/Rs2D: 0 cycles (combinational).
- A writeback to register r at edge N is visible to all reads after edge N.
- Same-cycle read/write of the same register is governed by Configuration.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read whose index equals RdW (≠0) while RegWriteW=1 returns ResultW combinationally (write-first).
  - RD1E/RD2E therefore capture the new value at that edge.
- Undefined:
  - Reads return the stored (old) value.
  - The hazard unit must stall or forward for a writeback→decode distance of 0.

## Structure
- Shared package `rv32i_pkg`:
  - opcode constants
  - `alu_op_t` (ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001, PASSB 1010)
  - `imm_src_t` (I, S, B, U, J)
  - `result_src_t`
- One sub-module: `regfile` (storage, x0 rule, bypass macro).
- Decoders and the extender stay inline in decode_stage.

## Test plan
- Reset: rst=0 mid-run with non-zero state → all E outputs 0 immediately; after release, reading x1–x31 gives 0.
- addi x5,x0,7 (0x00700293) → after one edge: RegWriteE=1, ALUSrcE=1, ImmExtE=7, RdE=5, ALUControlE=ADD, ResultSrcE=00.
- beq x0,x0,-4 (0xFE000EE3) → BranchE=1, ALUControlE=SUB, ImmExtE=0xFFFFFFFC, RegWriteE=0.
- Writeback x5=0xDEADBEEF while decoding add x6,x5,x0:
  - With REGFILE_BYPASS_EN: RD1E=0xDEADBEEF.
  - Without: RD1E holds the old x5; the next decode reads 0xDEADBEEF.
  - Writeback of 0x1234 to x0 → later reads of x0 give 0.
- FlushE=1 with lw x1,0(x2) in decode → E outputs all 0; a simultaneous writeback to x3 still lands.
- Illegal 0x0000007F → IllegalE=1, RegWriteE=MemWriteE=JumpE=BranchE=0.
